pwm_counter_gen: RTL and testbench

- Parametrised successor of the 10-bit enable/reset counter used by the DigitalPWM datapath.
- Adds a programmable period (top), edge-aligned or centre-aligned counting, and CHANNELS compare outputs producing PWM.
- Top, duty and mode settings are double-buffered so they only change at period boundaries.
- Sits between the register/control interface and the PWM output pins.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_compare_ch.sv | 32 +++
 rtl/pwm_counter_gen.sv | 116 +++++++++++
 tb/tb_pwm_counter_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared encodings and reset defaults for the PWM counter/compare datapath.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Fill bits for the width-parameterised reset values (top all-ones, duty zero).
  localparam logic TOP_RST  = 1'b1;
  localparam logic DUTY_RST = 1'b0;

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM compare channel: double-buffered duty and registered count<duty output.
module pwm_compare_ch
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             xfer,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_p;
  logic [WIDTH-1:0] duty_a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_p <= {WIDTH{DUTY_RST}};
      duty_a <= {WIDTH{DUTY_RST}};
      pwm    <= 1'b0;
    end else begin
      if (load) duty_p <= duty_in;
      if (xfer) duty_a <= duty_p;
      if (enable) pwm <= (count < duty_a);
    end
  end

endmodule

// File: rtl/pwm_counter_gen.sv
// Programmable edge/centre-aligned PWM timebase with shadowed mode/top and per-channel compares.
module pwm_counter_gen
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic                      mode_in,
  input  logic [WIDTH-1:0]          top_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  output logic [WIDTH-1:0]          out,
  output logic                      dir,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_end
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_e            mode_a, mode_p;
  logic [WIDTH-1:0] top_a, top_p;
  logic             pend_valid;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] out_d;
  logic             boundary;
  logic             xfer;

  always_comb begin
    out_d    = out;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (enable) begin
      if (top_a == '0) begin
        out_d    = '0;
        dir_d    = DIR_UP;
        boundary = 1'b1;
      end else if (mode_a == MODE_EDGE) begin
        dir_d = DIR_UP;
        if (out == top_a) begin
          out_d    = '0;
          boundary = 1'b1;
        end else begin
          out_d = out + ONE;
        end
      end else if (dir_q == DIR_UP) begin
        if (out == top_a) begin
          // With top=1 the turnaround lands on 0, so it is already the boundary.
          out_d = top_a - ONE;
          if (top_a == ONE) boundary = 1'b1;
          else              dir_d    = DIR_DOWN;
        end else begin
          out_d = out + ONE;
        end
      end else begin
        out_d = out - ONE;
        if (out == ONE) begin
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end
      end
    end
    xfer = pend_valid && (!enable || boundary);
    if (xfer) begin
      out_d = '0;
      dir_d = DIR_UP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      dir_q      <= DIR_UP;
      period_end <= 1'b0;
      mode_a     <= MODE_EDGE;
      top_a      <= {WIDTH{TOP_RST}};
      mode_p     <= MODE_EDGE;
      top_p      <= '0;
      pend_valid <= 1'b0;
    end else begin
      out        <= out_d;
      dir_q      <= dir_d;
      period_end <= boundary;
      // Transfer uses the pending set as it stood before this cycle's load.
      if (xfer) begin
        mode_a <= mode_p;
        top_a  <= top_p;
      end
      if (load) begin
        mode_p     <= mode_e'(mode_in);
        top_p      <= top_in;
        pend_valid <= 1'b1;
      end else if (xfer) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign dir = dir_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_compare_ch #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .load    (load),
      .xfer    (xfer),
      .count   (out),
      .duty_in (duty_in[i*WIDTH +: WIDTH]),
      .pwm     (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_counter_gen.sv
// Randomised bench for pwm_counter_gen against a phase-index reference model.
module tb_pwm_counter_gen;

  localparam int W  = 10;
  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          reset, enable, load, mode_in;
  logic [W-1:0]  top_in;
  logic [CH*W-1:0] duty_in;
  logic [W-1:0]  out;
  logic          dir;
  logic [CH-1:0] pwm;
  logic          period_end;

  pwm_counter_gen #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .mode_in    (mode_in),
    .top_in     (top_in),
    .duty_in    (duty_in),
    .out        (out),
    .dir        (dir),
    .pwm        (pwm),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: position within the period is a phase index; out/dir are derived from it.
  int m_phase, m_mode, m_top, p_mode, p_top, p_valid;
  int m_duty[CH];
  int p_duty[CH];
  logic [CH-1:0] m_pwm;
  logic          m_pe;

  logic [W+CH+1:0] actv;
  assign actv = {out, dir, pwm, period_end};

  function automatic int m_period();
    if (m_top == 0) return 1;
    return (m_mode != 0) ? 2 * m_top : m_top + 1;
  endfunction

  function automatic bit m_dir();
    return (m_mode != 0) && (m_top != 0) && (m_phase > m_top);
  endfunction

  function automatic int m_out();
    return m_dir() ? 2 * m_top - m_phase : m_phase;
  endfunction

  function automatic logic [W+CH+1:0] expv();
    return {W'(m_out()), m_dir(), m_pwm, m_pe};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_top = (1 << W) - 1;
    p_mode = 0; p_top = 0; p_valid = 0;
    for (int i = 0; i < CH; i++) begin m_duty[i] = 0; p_duty[i] = 0; end
    m_pwm = '0; m_pe = 1'b0;
  endtask

  task automatic model_step();
    int per, o;
    bit bnd, xf;
    per = m_period();
    o   = m_out();
    bnd = enable && (m_phase == per - 1);
    xf  = (p_valid != 0) && (!enable || bnd);
    m_pe = bnd;
    if (enable) begin
      for (int i = 0; i < CH; i++) m_pwm[i] = (o < m_duty[i]);
      m_phase = (m_phase + 1) % per;
    end
    if (xf) begin
      m_mode = p_mode; m_top = p_top; m_duty = p_duty; m_phase = 0;
    end
    if (load) begin
      p_mode = int'(mode_in); p_top = int'(top_in);
      for (int i = 0; i < CH; i++) p_duty[i] = int'(duty_in[i*W +: W]);
      p_valid = 1;
    end else if (xf) begin
      p_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic load_cfg(input logic md, input int top, input int d0, input int d1);
    load = 1'b1; mode_in = md; top_in = W'(top);
    duty_in = {W'(d1), W'(d0)};
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; load = 1'b0; mode_in = 1'b0; top_in = '0; duty_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (actv !== expv()) begin
      tests_failed++;
      $display("FAIL reset_state got=%h exp=%h", actv, expv());
    end
    reset = 1'b1; enable = 1'b1;
    for (int c = 0; c < 37; c++) begin
      tick();
      tests_run++;
      if (actv !== expv()) begin
        tests_failed++;
        $display("FAIL reset_prerun cyc=%0d got=%h exp=%h", c, actv, expv());
      end
    end
    tests_run++;
    if (out !== W'(37)) begin
      tests_failed++;
      $display("FAIL reset_count37 got=%0d exp=37", out);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (actv !== '0) begin
      tests_failed++;
      $display("FAIL reset_async got=%h exp=0", actv);
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_edge_wrap();
    int pe_cnt = 0;
    enable = 1'b1;
    for (int c = 0; c < 2048; c++) begin
      tick();
      pe_cnt += int'(period_end);
      tests_run++;
      if (actv !== expv()) begin
        tests_failed++;
        $display("FAIL edge_wrap cyc=%0d got=%h exp=%h", c, actv, expv());
      end
    end
    tests_run++;
    if (pe_cnt != 2) begin
      tests_failed++;
      $display("FAIL edge_wrap_pe_count got=%0d exp=2", pe_cnt);
    end
  endtask

  task automatic test_edge_prog();
    int p0 = 0, p1 = 0, pe_cnt = 0;
    enable = 1'b0;
    load_cfg(1'b0, 9, 3, 10);
    tick(); tick();
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c >= 10) p0 += int'(pwm[0]);
      p1 += int'(pwm[1]);
      pe_cnt += int'(period_end);
      tests_run++;
      if (actv !== expv()) begin
        tests_failed++;
        $display("FAIL edge_prog cyc=%0d got=%h exp=%h", c, actv, expv());
      end
    end
    tests_run++;
    if (p0 != 9 || p1 != 40 || pe_cnt != 4) begin
      tests_failed++;
      $display("FAIL edge_prog_counts got=%0d/%0d/%0d exp=9/40/4", p0, p1, pe_cnt);
    end
  endtask

  task automatic test_centre();
    int dn = 0;
    enable = 1'b0;
    load_cfg(1'b1, 4, 2, int'($urandom_range(0, 6)));
    tick(); tick();
    enable = 1'b1;
    for (int c = 0; c < 32; c++) begin
      tick();
      dn += int'(dir);
      tests_run++;
      if (actv !== expv()) begin
        tests_failed++;
        $display("FAIL centre cyc=%0d got=%h exp=%h", c, actv, expv());
      end
    end
    tests_run++;
    if (dn != 12) begin
      tests_failed++;
      $display("FAIL centre_dir_count got=%0d exp=12", dn);
    end
  endtask

  task automatic run_until(input int target, input string nm);
    int n = 0;
    while (m_out() != target && n < 40) begin
      tick(); n++;
      tests_run++;
      if (actv !== expv()) begin
        tests_failed++;
        $display("FAIL %s_wait got=%h exp=%h", nm, actv, expv());
      end
    end
    if (n >= 40) begin
      tests_run++; tests_failed++;
      $display("FAIL %s_timeout got=%0d exp=%0d", nm, m_out(), target);
    end
  endtask

  task automatic run_check(input int n, input string nm);
    for (int c = 0; c < n; c++) begin
      tick();
      tests_run++;
      if (actv !== expv()) begin
        tests_failed++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, actv, expv());
      end
    end
  endtask

  task automatic test_shadow();
    enable = 1'b0;
    load_cfg(1'b0, 9, 5, 7);
    tick();
    enable = 1'b1;
    run_until(5, "shadow_mid");
    load_cfg(1'b0, 4, 2, 3);
    run_check(25, "shadow_mid");
    run_until(4, "shadow_bnd");
    load_cfg(1'b0, 7, 6, 1);
    run_check(25, "shadow_bnd");
  endtask

  task automatic test_edge_cases();
    int pe_cnt = 0;
    enable = 1'b0;
    load_cfg(1'b0, 0, 0, 1);
    tick();
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      pe_cnt += int'(period_end);
      tests_run++;
      if (actv !== expv()) begin
        tests_failed++;
        $display("FAIL top0 cyc=%0d got=%h exp=%h", c, actv, expv());
      end
    end
    tests_run++;
    if (pe_cnt != 10) begin
      tests_failed++;
      $display("FAIL top0_pe_count got=%0d exp=10", pe_cnt);
    end
    enable = 1'b0;
    load_cfg(1'b0, 9, 4, 0);
    tick();
    enable = 1'b1;
    run_until(6, "freeze");
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (actv !== expv() || out !== W'(6) || period_end !== 1'b0) begin
        tests_failed++;
        $display("FAIL freeze cyc=%0d got=%h exp=%h", c, actv, expv());
      end
    end
    enable = 1'b1;
    run_check(20, "unfreeze");
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      int t;
      enable = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 11) == 0);
      t = int'($urandom_range(0, 23));
      mode_in = 1'($urandom_range(0, 1));
      top_in  = W'(t);
      duty_in = {W'($urandom_range(0, t + 2)), W'($urandom_range(0, t + 2))};
      tick();
      tests_run++;
      if (actv !== expv()) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, actv, expv());
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_wrap();
    test_edge_prog();
    test_centre();
    test_shadow();
    test_edge_cases();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
